// File: rtl/vga_timing_ctrl_pkg.sv
// Shared constants for the VGA timing controller: config register map,
// FSM state encodings and reset-default raster timing (640x480@60).
package vga_timing_pkg;

  localparam int COUNT_W      = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int CFG_ADDR_W   = 3;
  localparam int CFG_NUM      = 8;

  localparam logic [2:0] A_H_ACTIVE = 3'd0;
  localparam logic [2:0] A_H_FP     = 3'd1;
  localparam logic [2:0] A_H_SYNC   = 3'd2;
  localparam logic [2:0] A_H_BP     = 3'd3;
  localparam logic [2:0] A_V_ACTIVE = 3'd4;
  localparam logic [2:0] A_V_FP     = 3'd5;
  localparam logic [2:0] A_V_SYNC   = 3'd6;
  localparam logic [2:0] A_V_BP     = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Configuration bus of the VGA timing controller.
// master: writer/committer side; slave: the timing controller.
// Signals: i_Cfg_Wr/Addr/Data shadow write, i_Cfg_Commit apply request,
// o_Cfg_Pending commit outstanding, o_Cfg_Err one-cycle rejection pulse.
interface vga_timing_ctrl_if #(
  parameter int COUNT_W = vga_timing_pkg::COUNT_W
);
  import vga_timing_pkg::*;

  logic                  i_Cfg_Wr;
  logic [CFG_ADDR_W-1:0] i_Cfg_Addr;
  logic [COUNT_W-1:0]    i_Cfg_Data;
  logic                  i_Cfg_Commit;
  logic                  o_Cfg_Pending;
  logic                  o_Cfg_Err;

  modport master (
    output i_Cfg_Wr,
    output i_Cfg_Addr,
    output i_Cfg_Data,
    output i_Cfg_Commit,
    input  o_Cfg_Pending,
    input  o_Cfg_Err
  );

  modport slave (
    input  i_Cfg_Wr,
    input  i_Cfg_Addr,
    input  i_Cfg_Data,
    input  i_Cfg_Commit,
    output o_Cfg_Pending,
    output o_Cfg_Err
  );

endinterface

// File: rtl/vga_timing_ctrl_axis_counter.sv
// One raster axis: position counter plus registered sync decode.
// Ports: i_Run (running next cycle), i_Start (force 0), i_Step (advance),
// i_Total (current length, for wrap), i_Active_Len/i_Sync_Start/i_Sync_End
// (timing valid for the next cycle); o_Count, o_Sync_N registered,
// o_Count_Nxt/o_Act_Nxt/o_Last combinational.
module vga_axis_counter #(
  parameter int COUNT_W = 10
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_Run,
  input  logic               i_Start,
  input  logic               i_Step,
  input  logic [COUNT_W+1:0] i_Total,
  input  logic [COUNT_W-1:0] i_Active_Len,
  input  logic [COUNT_W+1:0] i_Sync_Start,
  input  logic [COUNT_W+1:0] i_Sync_End,
  output logic [COUNT_W-1:0] o_Count,
  output logic [COUNT_W-1:0] o_Count_Nxt,
  output logic               o_Last,
  output logic               o_Act_Nxt,
  output logic               o_Sync_N
);

  localparam int W2 = COUNT_W + 2;

  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] cnt_nxt;
  logic [W2-1:0]      cnt_x;
  logic               sync_n_q;
  logic               in_sync;

  assign o_Last = ({2'b00, cnt_q} == (i_Total - W2'(1)));

  always_comb begin
    cnt_nxt = cnt_q;
    if (!i_Run || i_Start) begin
      cnt_nxt = '0;
    end else if (i_Step) begin
      cnt_nxt = o_Last ? '0 : cnt_q + COUNT_W'(1);
    end
  end

  assign cnt_x = {2'b00, cnt_nxt};

  // Decode the position we are about to show so flags stay aligned.
  assign o_Act_Nxt = i_Run && (cnt_nxt < i_Active_Len);
  assign in_sync   = i_Run && (cnt_x >= i_Sync_Start)
                   && (cnt_x < i_Sync_End);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt_q    <= '0;
      sync_n_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_nxt;
      sync_n_q <= !in_sync;
    end
  end

  assign o_Count     = cnt_q;
  assign o_Count_Nxt = cnt_nxt;
  assign o_Sync_N    = sync_n_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// Programmable VGA raster generator with shadowed timing registers that are
// committed atomically at the frame boundary (or at once while idle).
// Ports: i_Clk, i_Rst_L (async, active low), i_Enable (run level),
// cfg (config bus, slave), o_HSync/o_VSync (active low), o_Active,
// o_Frame_Start, o_Col_Count, o_Row_Count.
// Option VGA_TIMING_LINE_IRQ_EN adds i_Irq_Line and o_Line_Irq.
module vga_timing_ctrl #(
  parameter int COUNT_W      = vga_timing_pkg::COUNT_W,
  parameter int H_ACTIVE_DEF = vga_timing_pkg::H_ACTIVE_DEF,
  parameter int H_FP_DEF     = vga_timing_pkg::H_FP_DEF,
  parameter int H_SYNC_DEF   = vga_timing_pkg::H_SYNC_DEF,
  parameter int H_BP_DEF     = vga_timing_pkg::H_BP_DEF,
  parameter int V_ACTIVE_DEF = vga_timing_pkg::V_ACTIVE_DEF,
  parameter int V_FP_DEF     = vga_timing_pkg::V_FP_DEF,
  parameter int V_SYNC_DEF   = vga_timing_pkg::V_SYNC_DEF,
  parameter int V_BP_DEF     = vga_timing_pkg::V_BP_DEF
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_Enable,
  vga_timing_ctrl_if.slave   cfg,
`ifdef VGA_TIMING_LINE_IRQ_EN
  input  logic [COUNT_W-1:0] i_Irq_Line,
  output logic               o_Line_Irq,
`endif
  output logic               o_HSync,
  output logic               o_VSync,
  output logic               o_Active,
  output logic               o_Frame_Start,
  output logic [COUNT_W-1:0] o_Col_Count,
  output logic [COUNT_W-1:0] o_Row_Count
);
  import vga_timing_pkg::*;

  localparam int W2 = COUNT_W + 2;
  localparam logic [W2-1:0] MAX_TOT = W2'(1) << COUNT_W;
  localparam logic [COUNT_W-1:0] DEF [CFG_NUM] = '{
    COUNT_W'(H_ACTIVE_DEF), COUNT_W'(H_FP_DEF),
    COUNT_W'(H_SYNC_DEF),   COUNT_W'(H_BP_DEF),
    COUNT_W'(V_ACTIVE_DEF), COUNT_W'(V_FP_DEF),
    COUNT_W'(V_SYNC_DEF),   COUNT_W'(V_BP_DEF)
  };

  function automatic logic [W2-1:0] tot4(
    input logic [COUNT_W-1:0] a,
    input logic [COUNT_W-1:0] b,
    input logic [COUNT_W-1:0] c,
    input logic [COUNT_W-1:0] d
  );
    return W2'(a) + W2'(b) + W2'(c) + W2'(d);
  endfunction

  logic [1:0]         state_q;
  logic [1:0]         state_nxt;
  logic [COUNT_W-1:0] shadow_q   [CFG_NUM];
  logic [COUNT_W-1:0] shadow_nxt [CFG_NUM];
  logic [COUNT_W-1:0] live_q     [CFG_NUM];
  logic [COUNT_W-1:0] live_nxt   [CFG_NUM];

  logic pending_q;
  logic err_q;
  logic active_q;
  logic fs_q;

  logic [W2-1:0] sh_htot;
  logic [W2-1:0] sh_vtot;
  logic [W2-1:0] htot_q;
  logic [W2-1:0] vtot_q;
  logic [W2-1:0] h_ss;
  logic [W2-1:0] h_se;
  logic [W2-1:0] v_ss;
  logic [W2-1:0] v_se;

  logic cfg_ok;
  logic apply;
  logic apply_ok;
  logic running;
  logic start;
  logic run_nxt;
  logic frame_last;
  logic frame_wrap;
  logic h_last;
  logic v_last;
  logic h_act_nxt;
  logic v_act_nxt;
  logic fs_nxt;

  logic [COUNT_W-1:0] h_cnt_nxt;
  logic [COUNT_W-1:0] v_cnt_nxt;

  assign running    = (state_q != ST_IDLE);
  assign start      = !running && i_Enable;
  assign frame_last = h_last && v_last;
  assign frame_wrap = running && frame_last;

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_Enable) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!i_Enable) begin
          state_nxt = frame_last ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (i_Enable) begin
          state_nxt = ST_RUN;
        end else if (frame_last) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign run_nxt = (state_nxt != ST_IDLE);

  // A write in the same cycle as a commit or an apply is part of it.
  always_comb begin
    for (int i = 0; i < CFG_NUM; i++) begin
      shadow_nxt[i] = shadow_q[i];
    end
    if (cfg.i_Cfg_Wr) begin
      shadow_nxt[cfg.i_Cfg_Addr] = cfg.i_Cfg_Data;
    end
  end

  assign sh_htot = tot4(shadow_nxt[A_H_ACTIVE], shadow_nxt[A_H_FP],
                        shadow_nxt[A_H_SYNC],   shadow_nxt[A_H_BP]);
  assign sh_vtot = tot4(shadow_nxt[A_V_ACTIVE], shadow_nxt[A_V_FP],
                        shadow_nxt[A_V_SYNC],   shadow_nxt[A_V_BP]);

  assign cfg_ok = (shadow_nxt[A_H_ACTIVE] != '0)
               && (shadow_nxt[A_V_ACTIVE] != '0)
               && (shadow_nxt[A_H_SYNC]   != '0)
               && (shadow_nxt[A_V_SYNC]   != '0)
               && (sh_htot <= MAX_TOT)
               && (sh_vtot <= MAX_TOT);

  // Idle applies at once; a running raster waits for the frame wrap.
  assign apply    = pending_q && (!running || frame_wrap);
  assign apply_ok = apply && cfg_ok;

  always_comb begin
    for (int i = 0; i < CFG_NUM; i++) begin
      live_nxt[i] = apply_ok ? shadow_nxt[i] : live_q[i];
    end
  end

  assign htot_q = tot4(live_q[A_H_ACTIVE], live_q[A_H_FP],
                       live_q[A_H_SYNC],   live_q[A_H_BP]);
  assign vtot_q = tot4(live_q[A_V_ACTIVE], live_q[A_V_FP],
                       live_q[A_V_SYNC],   live_q[A_V_BP]);

  // Region boundaries come from the timing in force next cycle.
  assign h_ss = W2'(live_nxt[A_H_ACTIVE]) + W2'(live_nxt[A_H_FP]);
  assign h_se = h_ss + W2'(live_nxt[A_H_SYNC]);
  assign v_ss = W2'(live_nxt[A_V_ACTIVE]) + W2'(live_nxt[A_V_FP]);
  assign v_se = v_ss + W2'(live_nxt[A_V_SYNC]);

  vga_axis_counter #(.COUNT_W(COUNT_W)) u_h (
    .i_Clk        (i_Clk),
    .i_Rst_L      (i_Rst_L),
    .i_Run        (run_nxt),
    .i_Start      (start),
    .i_Step       (running),
    .i_Total      (htot_q),
    .i_Active_Len (live_nxt[A_H_ACTIVE]),
    .i_Sync_Start (h_ss),
    .i_Sync_End   (h_se),
    .o_Count      (o_Col_Count),
    .o_Count_Nxt  (h_cnt_nxt),
    .o_Last       (h_last),
    .o_Act_Nxt    (h_act_nxt),
    .o_Sync_N     (o_HSync)
  );

  vga_axis_counter #(.COUNT_W(COUNT_W)) u_v (
    .i_Clk        (i_Clk),
    .i_Rst_L      (i_Rst_L),
    .i_Run        (run_nxt),
    .i_Start      (start),
    .i_Step       (running && h_last),
    .i_Total      (vtot_q),
    .i_Active_Len (live_nxt[A_V_ACTIVE]),
    .i_Sync_Start (v_ss),
    .i_Sync_End   (v_se),
    .o_Count      (o_Row_Count),
    .o_Count_Nxt  (v_cnt_nxt),
    .o_Last       (v_last),
    .o_Act_Nxt    (v_act_nxt),
    .o_Sync_N     (o_VSync)
  );

  assign fs_nxt = run_nxt && (h_cnt_nxt == '0) && (v_cnt_nxt == '0);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      active_q  <= 1'b0;
      fs_q      <= 1'b0;
      for (int i = 0; i < CFG_NUM; i++) begin
        shadow_q[i] <= DEF[i];
        live_q[i]   <= DEF[i];
      end
    end else begin
      state_q   <= state_nxt;
      pending_q <= apply ? 1'b0 : (pending_q | cfg.i_Cfg_Commit);
      err_q     <= apply && !cfg_ok;
      active_q  <= h_act_nxt && v_act_nxt;
      fs_q      <= fs_nxt;
      for (int i = 0; i < CFG_NUM; i++) begin
        shadow_q[i] <= shadow_nxt[i];
        live_q[i]   <= live_nxt[i];
      end
    end
  end

  assign o_Active          = active_q;
  assign o_Frame_Start     = fs_q;
  assign cfg.o_Cfg_Pending = pending_q;
  assign cfg.o_Cfg_Err     = err_q;

`ifdef VGA_TIMING_LINE_IRQ_EN
  logic [COUNT_W-1:0] irq_line_q;
  logic [COUNT_W-1:0] irq_line_nxt;
  logic               irq_q;

  // Line target tracks the input while idle, else latches at frame wrap.
  assign irq_line_nxt = (!running || frame_wrap) ? i_Irq_Line
                                                 : irq_line_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      irq_line_q <= COUNT_W'(V_ACTIVE_DEF);
      irq_q      <= 1'b0;
    end else begin
      irq_line_q <= irq_line_nxt;
      irq_q      <= run_nxt && (h_cnt_nxt == '0)
                 && (v_cnt_nxt == irq_line_nxt);
    end
  end

  assign o_Line_Irq = irq_q;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl: reset, default raster, small raster,
// commits, rejection, drain/re-enable, async reset, total-width limit.
module tb_vga_timing_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       hs;
  logic       vs;
  logic       act;
  logic       fs;
  logic [9:0] col;
  logic [9:0] row;
`ifdef VGA_TIMING_LINE_IRQ_EN
  logic [9:0] irq_line = 10'd0;
  logic       line_irq;
`endif

  int n_chk = 0;
  int n_err = 0;
  int c;
  int r;

  vga_timing_ctrl_if cfg_if ();

  vga_timing_ctrl dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Enable      (en),
    .cfg           (cfg_if),
`ifdef VGA_TIMING_LINE_IRQ_EN
    .i_Irq_Line    (irq_line),
    .o_Line_Irq    (line_irq),
`endif
    .o_HSync       (hs),
    .o_VSync       (vs),
    .o_Active      (act),
    .o_Frame_Start (fs),
    .o_Col_Count   (col),
    .o_Row_Count   (row)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic px(input string tag, input int ec, input int er,
                    input int ehs, input int evs, input int eact,
                    input int efs);
    chk({tag, "_col"}, int'(col), ec);
    chk({tag, "_row"}, int'(row), er);
    chk({tag, "_hs"}, int'(hs), ehs);
    chk({tag, "_vs"}, int'(vs), evs);
    chk({tag, "_act"}, int'(act), eact);
    chk({tag, "_fs"}, int'(fs), efs);
  endtask

  task automatic wr(input int a, input int d, input bit commit);
    cfg_if.i_Cfg_Wr     = 1'b1;
    cfg_if.i_Cfg_Addr   = 3'(a);
    cfg_if.i_Cfg_Data   = 10'(d);
    cfg_if.i_Cfg_Commit = commit;
    tick();
    cfg_if.i_Cfg_Wr     = 1'b0;
    cfg_if.i_Cfg_Commit = 1'b0;
  endtask

  task automatic commit_only();
    cfg_if.i_Cfg_Commit = 1'b1;
    tick();
    cfg_if.i_Cfg_Commit = 1'b0;
  endtask

  initial begin
    cfg_if.i_Cfg_Wr     = 1'b0;
    cfg_if.i_Cfg_Addr   = 3'd0;
    cfg_if.i_Cfg_Data   = 10'd0;
    cfg_if.i_Cfg_Commit = 1'b0;

    // Reset state
    tick(2);
    px("rst", 0, 0, 1, 1, 0, 0);
    chk("rst_pend", int'(cfg_if.o_Cfg_Pending), 0);
    chk("rst_err", int'(cfg_if.o_Cfg_Err), 0);
    rst_n = 1'b1;
    tick(2);
    px("idle", 0, 0, 1, 1, 0, 0);

    // Default 800x525 raster, first line
    en = 1'b1;
    tick();
    px("d0", 0, 0, 1, 1, 1, 1);
    tick();
    px("d1", 1, 0, 1, 1, 1, 0);
    tick(638);
    px("d639", 639, 0, 1, 1, 1, 0);
    tick();
    px("d640", 640, 0, 1, 1, 0, 0);
    tick(15);
    px("d655", 655, 0, 1, 1, 0, 0);
    tick();
    px("d656", 656, 0, 0, 1, 0, 0);
    tick(95);
    px("d751", 751, 0, 0, 1, 0, 0);
    tick();
    px("d752", 752, 0, 1, 1, 0, 0);
    tick(47);
    px("d799", 799, 0, 1, 1, 0, 0);
    tick();
    px("d_r1", 0, 1, 1, 1, 1, 0);

    // Pending commit then async reset mid-frame
    wr(0, 320, 1'b1);
    chk("pre_rst_pend", int'(cfg_if.o_Cfg_Pending), 1);
    tick(3);
    rst_n = 1'b0;
    #1;
    px("arst", 0, 0, 1, 1, 0, 0);
    chk("arst_pend", int'(cfg_if.o_Cfg_Pending), 0);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Shadow edit must be gone: commit in idle keeps HTOT=800
    commit_only();
    chk("idle_pend", int'(cfg_if.o_Cfg_Pending), 1);
    tick();
    chk("idle_apply_pend", int'(cfg_if.o_Cfg_Pending), 0);
    chk("idle_apply_err", int'(cfg_if.o_Cfg_Err), 0);
    en = 1'b1;
    tick();
    tick(479);
    chk("keep800_col", int'(col), 479);
    chk("keep800_row", int'(row), 0);
    rst_n = 1'b0;
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Small raster: H 8/2/3/3 (HTOT 16), V 6/1/2/1 (VTOT 10)
    wr(0, 8, 1'b0);
    wr(1, 2, 1'b0);
    wr(2, 3, 1'b0);
    wr(3, 3, 1'b0);
    wr(4, 6, 1'b0);
    wr(5, 1, 1'b0);
    wr(6, 2, 1'b0);
    wr(7, 1, 1'b1);
    chk("sm_pend", int'(cfg_if.o_Cfg_Pending), 1);
    tick();
    chk("sm_pend_clr", int'(cfg_if.o_Cfg_Pending), 0);
    chk("sm_err", int'(cfg_if.o_Cfg_Err), 0);
`ifdef VGA_TIMING_LINE_IRQ_EN
    irq_line = 10'd4;
`endif
    en = 1'b1;
    tick();
    for (int k = 0; k < 160; k++) begin
      c = k % 16;
      r = k / 16;
      px("frm", c, r, (c >= 10 && c < 13) ? 0 : 1,
         (r >= 7 && r < 9) ? 0 : 1, (c < 8 && r < 6) ? 1 : 0,
         (k == 0) ? 1 : 0);
`ifdef VGA_TIMING_LINE_IRQ_EN
      chk("irq", int'(line_irq), (c == 0 && r == 4) ? 1 : 0);
`endif
      tick();
    end
    px("frm2", 0, 0, 1, 1, 1, 1);

    // H_ACTIVE=4 committed at row 3: old timing until wrap
    tick(48);
    wr(0, 4, 1'b1);
    chk("h4_pend", int'(cfg_if.o_Cfg_Pending), 1);
    tick(110);
    chk("h4_old_col", int'(col), 15);
    chk("h4_old_row", int'(row), 9);
    chk("h4_old_pend", int'(cfg_if.o_Cfg_Pending), 1);
    tick();
    px("h4_new", 0, 0, 1, 1, 1, 1);
    chk("h4_pend_clr", int'(cfg_if.o_Cfg_Pending), 0);
    tick(11);
    chk("h4_last", int'(col), 11);
    tick();
    px("h4_r1", 0, 1, 1, 1, 1, 0);
    tick(4);
    px("h4_c4", 4, 1, 1, 1, 0, 0);
    tick(2);
    px("h4_c6", 6, 1, 0, 1, 0, 0);
    tick(3);
    px("h4_c9", 9, 1, 1, 1, 0, 0);

    // H_SYNC=0 commit is rejected at the wrap
    wr(2, 0, 1'b1);
    chk("bad_pend", int'(cfg_if.o_Cfg_Pending), 1);
    tick(97);
    chk("bad_wait_err", int'(cfg_if.o_Cfg_Err), 0);
    tick();
    chk("bad_err", int'(cfg_if.o_Cfg_Err), 1);
    chk("bad_pend_clr", int'(cfg_if.o_Cfg_Pending), 0);
    px("bad_wrap", 0, 0, 1, 1, 1, 1);
    tick();
    chk("bad_err_1cyc", int'(cfg_if.o_Cfg_Err), 0);
    tick(11);
    px("bad_keep", 0, 1, 1, 1, 1, 0);
    wr(2, 3, 1'b0);

    // Drop enable at row 3: frame completes then idles
    tick(23);
    chk("dr_row", int'(row), 3);
    en = 1'b0;
    tick(83);
    px("dr_last", 11, 9, 1, 1, 0, 0);
    tick();
    px("dr_idle", 0, 0, 1, 1, 0, 0);
    tick(3);
    px("dr_idle2", 0, 0, 1, 1, 0, 0);

    // Re-enable during drain: no break in the raster
    en = 1'b1;
    tick();
    px("re0", 0, 0, 1, 1, 1, 1);
    tick(36);
    en = 1'b0;
    tick(12);
    px("re_r4", 0, 4, 1, 1, 1, 0);
    en = 1'b1;
    tick(71);
    px("re_last", 11, 9, 1, 1, 0, 0);
    tick();
    px("re_wrap", 0, 0, 1, 1, 1, 1);

    // HTOT limit: 1025 rejected, 1024 accepted
    en = 1'b0;
    tick(120);
    px("lim_idle", 0, 0, 1, 1, 0, 0);
    wr(3, 1016, 1'b1);
    tick();
    chk("lim1025_err", int'(cfg_if.o_Cfg_Err), 1);
    chk("lim1025_pend", int'(cfg_if.o_Cfg_Pending), 0);
    wr(3, 1015, 1'b1);
    tick();
    chk("lim1024_err", int'(cfg_if.o_Cfg_Err), 0);
    chk("lim1024_pend", int'(cfg_if.o_Cfg_Pending), 0);
    en = 1'b1;
    tick();
    px("lim0", 0, 0, 1, 1, 1, 1);
    tick(1023);
    px("lim1023", 1023, 0, 1, 1, 0, 0);
    tick();
    px("lim_r1", 0, 1, 1, 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
